// File: rtl/fifo_rr_arbiter.sv
// Round-robin read scheduler that drains a bank of synchronous FIFOs into one
// valid/ready sink, one word at a time, tagging each word with its source index.
module fifo_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 1,
    parameter int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_fifo_empty,
    output logic [NUM_REQ-1:0]            o_fifo_read,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_fifo_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic [SRC_W-1:0]              o_src,
    output logic                          o_busy
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [SRC_W-1:0] GRANT_RST = SRC_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_RST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [SRC_W-1:0]        grant_q;
    logic [SRC_W-1:0]        grant_d;
    logic [CNT_W-1:0]        burst_q;
    logic [CNT_W-1:0]        burst_d;
    logic [NUM_REQ-1:0]      read_q;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [SRC_W-1:0]        src_q;
    logic                    busy_q;
    logic [NUM_REQ-1:0]      req_s;
    logic                    any_req_s;
    logic [DATA_WIDTH-1:0]   slot_data_s;

    // First requester after 'last', scanning cyclically so 'last' itself is tried last.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic [SRC_W-1:0]   last);
        logic [SRC_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found && req[SRC_W'(idx)]) begin
                pick  = SRC_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SRC_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = {NUM_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Next grant and burst count; only consumed at IDLE and at a HOLD transfer edge.
    always_comb begin
        req_s       = ~i_fifo_empty;
        any_req_s   = |req_s;
        slot_data_s = i_fifo_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        if (req_s[grant_q] && (int'(burst_q) < BURST_LEN - 1)) begin
            grant_d = grant_q;
            burst_d = burst_q + CNT_W'(1'b1);
        end else begin
            grant_d = rr_pick(req_s, grant_q);
            burst_d = {CNT_W{1'b0}};
        end
    end

    // Scheduler FSM; the read strobe is registered on entry to FETCH so it lasts exactly that cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= GRANT_RST;
            burst_q <= BURST_RST;
            read_q  <= {NUM_REQ{1'b0}};
            valid_q <= 1'b0;
            data_q  <= {DATA_WIDTH{1'b0}};
            src_q   <= {SRC_W{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            read_q <= {NUM_REQ{1'b0}};
            case (state_q)
                S_IDLE: begin
                    if (any_req_s) begin
                        grant_q <= grant_d;
                        burst_q <= burst_d;
                        read_q  <= onehot(grant_d);
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    data_q  <= slot_data_s;
                    src_q   <= grant_q;
                    valid_q <= 1'b1;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        if (any_req_s) begin
                            grant_q <= grant_d;
                            burst_q <= burst_d;
                            read_q  <= onehot(grant_d);
                            state_q <= S_FETCH;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_fifo_read = read_q;
    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_src       = src_q;
    assign o_busy      = busy_q;

endmodule
